// File: rtl/load_pkg.sv
// load_pkg: load type encodings, FSM states and per-type size/sign helpers.
package load_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, LWU, LD, ILLEGAL} load_type_t;
  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE, FAULT} state_t;
  function automatic logic [3:0] size_bytes(logic [2:0] t);
    return (t == LB || t == LBU) ? 4'd1 : (t == LH || t == LHU) ? 4'd2 : (t == LD) ? 4'd8 : 4'd4;
  endfunction
  function automatic logic is_signed(logic [2:0] t);
    return t == LB || t == LH || t == LW;
  endfunction
  function automatic logic is_illegal(logic [2:0] t, int xlen);
    return t == ILLEGAL || (xlen == 32 && (t == LWU || t == LD));
  endfunction
endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: pipeline request, memory port and result handshakes of the load unit.
interface load_unit_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              req_valid, req_ready;
  logic [2:0]        req_load_type;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_rd;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;
  logic              rsp_valid, rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic [4:0]        rsp_rd;
  logic              rsp_fault;
  modport slave (
    input  req_valid, req_load_type, req_addr, req_rd, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
    output req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );
  modport master (
    output req_valid, req_load_type, req_addr, req_rd, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
    input  req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_rd, rsp_fault
  );
endinterface

// File: rtl/load_extract.sv
// load_extract: selects the addressed bytes from a word pair and sign/zero-extends them.
module load_extract import load_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             word1,
  input  logic [XLEN-1:0]             word0,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [2:0]                  load_type,
  output logic [XLEN-1:0]             result
);
  localparam int IW = $clog2(XLEN);
  logic [XLEN-1:0] sh, mask;
  logic [7:0]      nb;
  logic [IW-1:0]   top;
  logic            sgn;
  always_comb begin
    sh = XLEN'({word1, word0} >> {offset, 3'b000});
    nb = {1'b0, size_bytes(load_type), 3'b000};
    top = IW'(nb - 8'd1);
    mask = (nb >= 8'(XLEN)) ? '1 : (XLEN'(1) << nb) - XLEN'(1);
    sgn = is_signed(load_type) && (nb < 8'(XLEN)) && sh[top];
    result = (sh & mask) | ({XLEN{sgn}} & ~mask);
  end
endmodule

// File: rtl/load_unit.sv
// load_unit: one-at-a-time load FSM issuing one or two aligned word reads and returning the extended result.
module load_unit import load_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input logic        clk,
  input logic        rst,
  load_unit_if.slave bus
);
  localparam int WB = XLEN / 8;
  localparam int OW = $clog2(WB);
  state_t            state, state_n;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] addr_q, aligned;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   word0, word1, ext;
  function automatic logic crosses(logic [2:0] t, logic [OW-1:0] off);
    return (5'(off) + 5'(size_bytes(t))) > 5'(WB);
  endfunction
  assign aligned = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  load_extract #(.XLEN(XLEN)) u_extract (
    .word1(word1), .word0(word0), .offset(addr_q[OW-1:0]), .load_type(type_q), .result(ext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      type_q <= '0;
      addr_q <= '0;
      rd_q <= '0;
      word0 <= '0;
      word1 <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        type_q <= bus.req_load_type;
        addr_q <= bus.req_addr;
        rd_q <= bus.req_rd;
        word1 <= '0;
      end
      if (state == WAIT_LO && bus.mem_rsp_valid) word0 <= bus.mem_rsp_data;
      if (state == WAIT_HI && bus.mem_rsp_valid) word1 <= bus.mem_rsp_data;
    end
  end
  always_comb begin
    state_n = state;
    bus.req_ready = state == IDLE;
    bus.mem_req_valid = state == REQ_LO || state == REQ_HI;
    bus.mem_req_addr = (state == REQ_LO) ? aligned : (state == REQ_HI) ? aligned + ADDR_W'(WB) : '0;
    bus.rsp_valid = state == DONE || state == FAULT;
    bus.rsp_data = (state == DONE) ? ext : '0;
    bus.rsp_rd = rd_q;
    bus.rsp_fault = state == FAULT;
    case (state)
      IDLE:    if (bus.req_valid)
                 state_n = (is_illegal(bus.req_load_type, XLEN) ||
                            (MISALIGN_SPLIT == 0 && crosses(bus.req_load_type, bus.req_addr[OW-1:0]))) ? FAULT : REQ_LO;
      REQ_LO:  if (bus.mem_req_ready) state_n = WAIT_LO;
      WAIT_LO: if (bus.mem_rsp_valid) state_n = crosses(type_q, addr_q[OW-1:0]) ? REQ_HI : DONE;
      REQ_HI:  if (bus.mem_req_ready) state_n = WAIT_HI;
      WAIT_HI: if (bus.mem_rsp_valid) state_n = DONE;
      DONE,
      FAULT:   if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed vectors against split/no-split XLEN=32 and XLEN=64 load units.
module tb_load_unit;
  import load_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  load_unit_if #(.XLEN(32), .ADDR_W(32)) a ();
  load_unit_if #(.XLEN(32), .ADDR_W(32)) b ();
  load_unit_if #(.XLEN(64), .ADDR_W(32)) c ();
  load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_a (.clk(clk), .rst(rst), .bus(a));
  load_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_b (.clk(clk), .rst(rst), .bus(b));
  load_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_c (.clk(clk), .rst(rst), .bus(c));
  int errs = 0, checks = 0;
  // memory model for a: responds a_dly cycles after the request handshake
  int a_cnt = -1, a_dly = 0, c_cnt = -1;
  logic a_rdy = 1, b_touch = 0;
  logic [31:0] a_addr = 0, a_base = 0, a_w0 = 0, a_w1 = 0;
  logic [31:0] a_log[$], c_log[$];
  always @(posedge clk) begin
    if (a.mem_req_valid && a.mem_req_ready) begin
      a_addr <= a.mem_req_addr;
      a_cnt <= a_dly;
      a_log.push_back(a.mem_req_addr);
    end else if (a_cnt >= 0) a_cnt <= a_cnt - 1;
    if (c.mem_req_valid && c.mem_req_ready) begin
      c_cnt <= 0;
      c_log.push_back(c.mem_req_addr);
    end else if (c_cnt >= 0) c_cnt <= c_cnt - 1;
    if (b.mem_req_valid) b_touch <= 1'b1;
  end
  assign a.mem_req_ready = a_rdy;
  assign a.mem_rsp_valid = (a_cnt == 0);
  assign a.mem_rsp_data = (a_addr == a_base) ? a_w0 : a_w1;
  assign b.mem_req_ready = 1'b1;
  assign b.mem_rsp_valid = 1'b0;
  assign b.mem_rsp_data = '0;
  assign c.mem_req_ready = 1'b1;
  assign c.mem_rsp_valid = (c_cnt == 0);
  assign c.mem_rsp_data = 64'h8000_0000_0000_0001;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int u, input logic v, input logic [2:0] t, input logic [31:0] addr, input logic [4:0] rd);
    if (u == 0) begin a.req_valid = v; a.req_load_type = t; a.req_addr = addr; a.req_rd = rd; end
    else if (u == 1) begin b.req_valid = v; b.req_load_type = t; b.req_addr = addr; b.req_rd = rd; end
    else begin c.req_valid = v; c.req_load_type = t; c.req_addr = addr; c.req_rd = rd; end
  endtask
  function automatic logic rv(input int u);
    return u == 0 ? a.rsp_valid : u == 1 ? b.rsp_valid : c.rsp_valid;
  endfunction
  task automatic do_load(input int u, input logic [2:0] t, input logic [31:0] addr, input logic [4:0] rd,
                         output logic [63:0] d, output logic f, output logic [4:0] r, output int lat);
    drive(u, 1'b1, t, addr, rd);
    @(posedge clk); #1;
    drive(u, 1'b0, t, addr, rd);
    lat = 1;
    while (!rv(u) && lat < 40) begin @(posedge clk); #1; lat++; end
    d = u == 0 ? 64'(a.rsp_data) : u == 1 ? 64'(b.rsp_data) : c.rsp_data;
    f = u == 0 ? a.rsp_fault : u == 1 ? b.rsp_fault : c.rsp_fault;
    r = u == 0 ? a.rsp_rd : u == 1 ? b.rsp_rd : c.rsp_rd;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] d;
    logic f, ok;
    logic [4:0] r;
    int lat, n;
    for (int u = 0; u < 3; u++) drive(u, 1'b0, LB, 32'h0, 5'd0);
    a.rsp_ready = 1; b.rsp_ready = 1; c.rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", a.req_ready, 1);
    chk("rst_mem_req_valid", a.mem_req_valid, 0);
    chk("rst_mem_req_addr", a.mem_req_addr, 0);
    chk("rst_rsp_valid", a.rsp_valid, 0);
    chk("rst_rsp_data", a.rsp_data, 0);
    chk("rst_rsp_rd", a.rsp_rd, 0);
    chk("rst_rsp_fault", a.rsp_fault, 0);
    rst = 0;
    a_base = 32'h1000; a_w0 = 32'h8012_3456; a_log.delete();
    do_load(0, LB, 32'h1003, 5'd5, d, f, r, lat);
    chk("lb_data", d, 64'hFFFF_FF80);
    chk("lb_fault", f, 0);
    chk("lb_rd", r, 5);
    chk("lb_latency", lat, 3);
    chk("lb_nreq", a_log.size(), 1);
    chk("lb_addr", a_log[0], 32'h1000);
    a_w0 = 32'hAABB_CCDD; a_w1 = 32'h1122_3344; a_log.delete();
    do_load(0, LHU, 32'h1003, 5'd12, d, f, r, lat);
    chk("lhu_split_data", d, 64'h44AA);
    chk("lhu_split_latency", lat, 5);
    chk("lhu_split_nreq", a_log.size(), 2);
    chk("lhu_split_addr0", a_log[0], 32'h1000);
    chk("lhu_split_addr1", a_log[1], 32'h1004);
    a_base = 32'hFFFF_FFFC; a_w0 = 32'h1234_5678; a_w1 = 32'h0000_00A5; a_log.delete();
    do_load(0, LH, 32'hFFFF_FFFF, 5'd31, d, f, r, lat);
    chk("lh_wrap_data", d, 64'hFFFF_A512);
    chk("lh_wrap_addr0", a_log[0], 32'hFFFF_FFFC);
    chk("lh_wrap_addr1", a_log[1], 32'h0);
    do_load(0, ILLEGAL, 32'h1000, 5'd3, d, f, r, lat);
    chk("a_illegal_fault", {f, lat[3:0]}, {1'b1, 4'd1});
    do_load(0, LWU, 32'h1000, 5'd3, d, f, r, lat);
    chk("a_lwu32_fault", {f, lat[3:0]}, {1'b1, 4'd1});
    chk("a_lwu32_data", d, 0);
    do_load(1, LW, 32'h2002, 5'd9, d, f, r, lat);
    chk("nosplit_lw_fault", f, 1);
    chk("nosplit_lw_data", d, 0);
    chk("nosplit_lw_latency", lat, 1);
    chk("nosplit_lw_rd", r, 9);
    do_load(1, ILLEGAL, 32'h2000, 5'd4, d, f, r, lat);
    chk("nosplit_illegal", {f, lat[3:0], d}, {1'b1, 4'd1, 64'h0});
    chk("nosplit_no_mem_access", b_touch, 0);
    c_log.delete();
    do_load(2, LD, 32'h08, 5'd1, d, f, r, lat);
    chk("x64_ld_data", d, 64'h8000_0000_0000_0001);
    chk("x64_ld_addr", c_log[0], 32'h08);
    chk("x64_ld_latency", lat, 3);
    do_load(2, LWU, 32'h0C, 5'd2, d, f, r, lat);
    chk("x64_lwu_data", d, 64'h0000_0000_8000_0000);
    do_load(2, LW, 32'h0C, 5'd3, d, f, r, lat);
    chk("x64_lw_data", d, 64'hFFFF_FFFF_8000_0000);
    chk("x64_lw_fault", f, 0);
    a_rdy = 0; a_base = 32'h1000; a_w0 = 32'hDEAD_BEEF;
    drive(0, 1'b1, LW, 32'h1000, 5'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, LW, 32'h1000, 5'd7);
    ok = 1;
    repeat (4) begin
      ok = ok && a.mem_req_valid && a.mem_req_addr == 32'h1000 && !a.req_ready;
      @(posedge clk); #1;
    end
    chk("bp_mem_req_stable", ok, 1);
    a_rdy = 1; a.rsp_ready = 0; n = 0;
    while (!a.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    ok = 1;
    repeat (3) begin
      ok = ok && a.rsp_valid && a.rsp_data == 32'hDEAD_BEEF && a.rsp_rd == 5'd7 && !a.rsp_fault && !a.req_ready;
      @(posedge clk); #1;
    end
    chk("bp_rsp_stable", ok, 1);
    a.rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_back_idle", a.req_ready, 1);
    a_dly = 3;
    drive(0, 1'b1, LW, 32'h1000, 5'd9);
    @(posedge clk); #1;
    drive(0, 1'b0, LW, 32'h1000, 5'd9);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_outputs", {a.req_ready, a.mem_req_valid, a.rsp_valid, a.rsp_fault, a.rsp_rd, a.mem_req_addr},
        {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0});
    ok = 1;
    repeat (5) begin
      ok = ok && a.req_ready && !a.rsp_valid && !a.mem_req_valid;
      @(posedge clk); #1;
    end
    chk("late_rsp_ignored", ok, 1);
    a_dly = 0; a_w0 = 32'h0000_7F00;
    do_load(0, LB, 32'h1001, 5'd17, d, f, r, lat);
    chk("recover_data", d, 64'h7F);
    chk("recover_rd", r, 17);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
